// File: rtl/coax_rx_bit_timer.sv
// Receive bit timer for the biphase coax line: synchronizes rx, locks a bit-period counter to
// mid-bit transitions and produces half-bit sampling strobes for the deserializer.
module coax_rx_bit_timer #(
  parameter int unsigned CLOCKS_PER_BIT = 8,
  parameter int unsigned TOLERANCE      = 1,
  parameter int unsigned LOSS_BITS      = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_sync,
  output logic locked,
  output logic first_sample_strobe,
  output logic second_sample_strobe,
  output logic bit_strobe,
  output logic first_half,
  output logic second_half
);

  localparam int unsigned CW = $clog2(CLOCKS_PER_BIT) + 1;
  localparam int unsigned MW = $clog2(LOSS_BITS + 1);

  localparam logic [CW-1:0] Mid     = CW'(CLOCKS_PER_BIT / 2);
  localparam logic [CW-1:0] MidNext = CW'(CLOCKS_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] WinLo   = CW'(CLOCKS_PER_BIT / 2 - TOLERANCE);
  localparam logic [CW-1:0] WinHi   = CW'(CLOCKS_PER_BIT / 2 + TOLERANCE);
  localparam logic [CW-1:0] Quarter = CW'(CLOCKS_PER_BIT / 4);
  localparam logic [CW-1:0] ThreeQ  = CW'(3 * CLOCKS_PER_BIT / 4);
  localparam logic [CW-1:0] Last    = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [MW-1:0] LossMax = MW'(LOSS_BITS);

  typedef enum logic {StUnlocked, StLocked} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   counter_q, counter_d;
  logic [MW-1:0]   missed_q, missed_d;
  logic [MW-1:0]   missed_inc;
  logic            mid_seen_q, mid_seen_d;
  logic            rx_s1_q, rx_s2_q, rx_d_q;
  logic            rx_edge;
  logic            in_window;
  logic            at_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q    <= 1'b0;
      rx_s2_q    <= 1'b0;
      rx_d_q     <= 1'b0;
      state_q    <= StUnlocked;
      counter_q  <= '0;
      missed_q   <= '0;
      mid_seen_q <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_d_q     <= rx_s2_q;
      state_q    <= state_d;
      counter_q  <= counter_d;
      missed_q   <= missed_d;
      mid_seen_q <= mid_seen_d;
    end
  end

  assign rx_edge    = rx_s2_q != rx_d_q;
  assign in_window  = (counter_q >= WinLo) && (counter_q <= WinHi);
  assign at_last    = counter_q == Last;
  assign missed_inc = missed_q + MW'(1);

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    missed_d   = missed_q;
    mid_seen_d = mid_seen_q;
    unique case (state_q)
      StUnlocked: begin
        counter_d = '0;
        // The first edge seen is assumed to be mid-bit; its cycle counts as Mid.
        if (rx_edge) begin
          state_d    = StLocked;
          counter_d  = MidNext;
          mid_seen_d = 1'b1;
          missed_d   = '0;
        end
      end
      StLocked: begin
        counter_d = at_last ? '0 : counter_q + CW'(1);
        // Edges outside the window are bit-boundary transitions and only free-run.
        if (rx_edge && in_window) begin
          counter_d  = MidNext;
          mid_seen_d = 1'b1;
        end
        if (at_last) begin
          mid_seen_d = 1'b0;
          if (mid_seen_q) begin
            missed_d = '0;
          end else if (missed_inc == LossMax) begin
            state_d   = StUnlocked;
            counter_d = '0;
            missed_d  = '0;
          end else begin
            missed_d = missed_inc;
          end
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  assign rx_sync              = rx_s2_q;
  assign locked               = state_q == StLocked;
  assign first_sample_strobe  = locked && (counter_q == Quarter);
  assign second_sample_strobe = locked && (counter_q == ThreeQ);
  assign bit_strobe           = locked && at_last;
  assign first_half           = locked && (counter_q < Mid);
  assign second_half          = locked && (counter_q >= Mid);

endmodule
